// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential divider.
package div_pkg;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } div_state_e;

  localparam logic [DIV_W-1:0] DBZ_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/addsub32.sv
// Two's-complement adder/subtractor: s = a + b when sub=0, a - b when sub=1.
module addsub32 #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] s_o
);

  assign s_o = a_i + (b_i ^ {W{sub_i}}) + W'(sub_i);

endmodule

// File: rtl/div_step.sv
// One non-restoring division step on the {remainder, quotient} pair.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W:0]   rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] shifted;

  assign shifted = {rem_i[W-1:0], quo_i[W-1]};

  // Negative partial remainder adds the divisor back, otherwise subtract.
  addsub32 #(.W(W+1)) u_addsub (
    .a_i   (shifted),
    .b_i   ({1'b0, dvs_i}),
    .sub_i (~rem_i[W]),
    .s_o   (rem_o)
  );

  assign quo_o = {quo_i[W-2:0], ~rem_o[W]};

endmodule

// File: rtl/div32_seq.sv
// Iterative signed/unsigned divider: one quotient bit per cycle, then a
// sign fix-up cycle that loads q/r/dbz and pulses ready.
module div32_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             ready,
  output logic             dbz
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_mag_q, dvd_mag_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] rem_fix, rem_mag;
  logic [WIDTH-1:0] neg_q_in, neg_q_out;
  logic [WIDTH-1:0] neg_r_in, neg_r_out;
  logic             div_zero;

  div_step #(.W(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  addsub32 #(.W(WIDTH)) u_restore (
    .a_i   (rem_q[WIDTH-1:0]),
    .b_i   (dvs_q),
    .sub_i (1'b0),
    .s_o   (rem_fix)
  );

  // Negators take the operands when idle and the results during FIX.
  addsub32 #(.W(WIDTH)) u_neg_q (
    .a_i   ('0),
    .b_i   (neg_q_in),
    .sub_i (1'b1),
    .s_o   (neg_q_out)
  );

  addsub32 #(.W(WIDTH)) u_neg_r (
    .a_i   ('0),
    .b_i   (neg_r_in),
    .sub_i (1'b1),
    .s_o   (neg_r_out)
  );

  assign div_zero = (dvs_q == '0);
  // On divide-by-zero the dividend magnitude re-signed gives back the original a.
  assign rem_mag  = div_zero ? dvd_mag_q
                  : (rem_q[WIDTH] ? rem_fix : rem_q[WIDTH-1:0]);
  assign neg_q_in = (state_q == FIX) ? quo_q   : a;
  assign neg_r_in = (state_q == FIX) ? rem_mag : b;

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    busy_d  = (state_d != IDLE);
    ready_d = (state_q == FIX);
  end

  // Datapath next-state
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    dvd_mag_d = dvd_mag_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    q_d       = q_q;
    r_d       = r_q;
    dbz_d     = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_mag_d = (sign && a[WIDTH-1]) ? neg_q_out : a;
          dvs_d     = (sign && b[WIDTH-1]) ? neg_r_out : b;
          quo_d     = dvd_mag_d;
          rem_d     = '0;
          cnt_d     = '0;
          qneg_d    = sign && (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d    = sign && a[WIDTH-1];
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
      end
      FIX: begin
        q_d   = div_zero ? WIDTH'(DBZ_QUOT) : (qneg_q ? neg_q_out : quo_q);
        r_d   = rneg_q ? neg_r_out : rem_mag;
        dbz_d = div_zero;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dvd_mag_q <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      dvd_mag_q <= dvd_mag_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      q_q       <= q_d;
      r_q       <= r_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign q     = q_q;
  assign r     = r_q;
  assign dbz   = dbz_q;
  assign busy  = busy_q;
  assign ready = ready_q;

endmodule
